// File: rtl/param_alu.sv
// param_alu: WIDTH-bit accumulator ALU with V/C/N/Z flags,
// carry chaining and a serial shift-add multiplier.
module param_alu #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       status,
  output logic             busy
);

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ADC  = 4'h4;
  localparam logic [3:0] OP_SBB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_RDHI = 4'hD;
  localparam logic [3:0] OP_ZERO = 4'hE;
  localparam logic [3:0] OP_STAT = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   accum_q;
  logic [WIDTH-1:0]   hi_q;
  logic [3:0]         status_q;
  logic               show_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               accept;
  logic               cin;
  logic               big;
  logic               wr;
  logic               c_n;
  logic               v_n;
  logic [WIDTH-1:0]   res;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     step_w;
  logic [2*WIDTH-1:0] shl_w;
  logic [2*WIDTH-1:0] shr_w;
  logic [2*WIDTH-1:0] prod_d;

  assign busy     = (state_q == S_MUL);
  assign op_ready = !busy;
  assign accept   = op_valid & op_ready;
  assign status   = status_q;
  assign data_out = show_q ? {{(WIDTH-4){1'b0}}, status_q} : accum_q;

  // multiplier lives in prod_q low half and drains one bit per step
  assign step_w = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_d = {step_w, prod_q[WIDTH-1:1]};

  always_comb begin
    cin   = status_q[2] & ((opcode == OP_ADC) || (opcode == OP_SBB));
    add_w = {1'b0, accum_q} + {1'b0, data_in} + {{WIDTH{1'b0}}, cin};
    sub_w = {1'b0, accum_q} - {1'b0, data_in} - {{WIDTH{1'b0}}, cin};
    shl_w = {{WIDTH{1'b0}}, accum_q} << data_in;
    shr_w = {accum_q, {WIDTH{1'b0}}} >> data_in;
    big   = data_in > WIDTH'(WIDTH);
    res   = accum_q;
    c_n   = 1'b0;
    v_n   = 1'b0;
    wr    = 1'b0;
    unique case (1'b1)
      opcode == OP_LOAD: begin
        res = data_in;
        wr  = 1'b1;
      end
      (opcode == OP_ADD) || (opcode == OP_ADC): begin
        res = add_w[WIDTH-1:0];
        c_n = add_w[WIDTH];
        v_n = (accum_q[WIDTH-1] == data_in[WIDTH-1])
           && (res[WIDTH-1] != accum_q[WIDTH-1]);
        wr  = 1'b1;
      end
      (opcode == OP_SUB) || (opcode == OP_SBB): begin
        res = sub_w[WIDTH-1:0];
        c_n = sub_w[WIDTH];
        v_n = (accum_q[WIDTH-1] != data_in[WIDTH-1])
           && (res[WIDTH-1] != accum_q[WIDTH-1]);
        wr  = 1'b1;
      end
      opcode == OP_AND: begin
        res = accum_q & data_in;
        wr  = 1'b1;
      end
      opcode == OP_OR: begin
        res = accum_q | data_in;
        wr  = 1'b1;
      end
      opcode == OP_XOR: begin
        res = accum_q ^ data_in;
        wr  = 1'b1;
      end
      opcode == OP_NOT: begin
        res = ~accum_q;
        wr  = 1'b1;
      end
      opcode == OP_SHL: begin
        res = big ? '0 : shl_w[WIDTH-1:0];
        c_n = !big & shl_w[WIDTH];
        wr  = 1'b1;
      end
      opcode == OP_SHR: begin
        res = big ? '0 : shr_w[2*WIDTH-1:WIDTH];
        c_n = !big & shr_w[WIDTH-1];
        wr  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      accum_q  <= '0;
      hi_q     <= '0;
      status_q <= '0;
      show_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
    end else begin
      show_q <= accept && (opcode == OP_STAT);
      if (state_q == S_MUL) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_q  <= S_IDLE;
          accum_q  <= prod_d[WIDTH-1:0];
          hi_q     <= prod_d[2*WIDTH-1:WIDTH];
          status_q <= {1'b0, |prod_d[2*WIDTH-1:WIDTH],
                       prod_d[WIDTH-1], prod_d == '0};
        end
      end else if (accept) begin
        unique case (1'b1)
          opcode == OP_MUL: begin
            state_q <= S_MUL;
            cnt_q   <= '0;
            mcand_q <= accum_q;
            prod_q  <= {{WIDTH{1'b0}}, data_in};
          end
          opcode == OP_RDHI: begin
            accum_q  <= hi_q;
            status_q <= {status_q[3:2], hi_q[WIDTH-1], hi_q == '0};
          end
          opcode == OP_ZERO: begin
            accum_q  <= '0;
            status_q <= 4'b0001;
          end
          wr: begin
            accum_q  <= res;
            status_q <= {v_n, c_n, res[WIDTH-1], res == '0};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
